// File: rtl/sort4_ctrl_pkg.sv
// Shared types and sizing helpers for the sort4_ctrl bubble-sort sequencer.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_ELEM_DEF = 4;

  // Number of element pairs compared by a full bubble sort of n elements.
  function automatic int num_pairs(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  localparam int NUM_PAIRS = num_pairs(NUM_ELEM_DEF);

  // Width of a counter that must hold every value from 0 to num_pairs(n).
  function automatic int cnt_width(input int n);
    int pairs;
    pairs = num_pairs(n);
    return (pairs < 1) ? 1 : $clog2(pairs + 1);
  endfunction

endpackage

// File: rtl/sort4_ctrl_signed_cmp.sv
// Combinational signed magnitude comparator shared by all element pairs.
module signed_cmp #(
  parameter int W = 4
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic                gt,
  output logic                eq,
  output logic                lt
);

  assign gt = ($signed(a) >  $signed(b));
  assign eq = ($signed(a) == $signed(b));
  assign lt = ($signed(a) <  $signed(b));

endmodule

// File: rtl/sort4_ctrl.sv
// Bubble-sort controller: loads a vector, walks adjacent pairs through one
// shared signed comparator, swaps out-of-order pairs and exits early once a
// pass makes no swap.
module sort4_ctrl
  import sort_pkg::*;
#(
  parameter int W        = 4,
  parameter int NUM_ELEM = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_ELEM*W-1:0]         din,
  output logic [NUM_ELEM*W-1:0]         dout,
  output logic                          busy,
  output logic                          done,
  output logic [cnt_width(NUM_ELEM)-1:0] swap_count
);

  localparam int             CW     = cnt_width(NUM_ELEM);
  localparam int             IW     = (NUM_ELEM > 2) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IW-1:0]  LAST_P = IW'(NUM_ELEM - 2);

  state_t              state_r, state_nx_s;
  logic signed [W-1:0] elem_r [NUM_ELEM];
  logic [IW-1:0]       p_r, i_r, i_b_s, last_i_s;
  logic                flag_r;
  logic [CW-1:0]       cnt_r;
  logic                busy_r, done_r, busy_nx_s, done_nx_s;
  logic signed [W-1:0] cmp_a_s, cmp_b_s;
  logic                gt_s, eq_s, lt_s;
  logic                swap_s, load_s, end_pass_s, pass_swap_s, finish_s;

  // Pair-select muxes feed the single comparator with r[i] and r[i+1].
  assign i_b_s   = i_r + IW'(1);
  assign cmp_a_s = elem_r[i_r];
  assign cmp_b_s = elem_r[i_b_s];

  signed_cmp #(.W(W)) u_cmp (
    .a  (cmp_a_s),
    .b  (cmp_b_s),
    .gt (gt_s),
    .eq (eq_s),
    .lt (lt_s)
  );

  // Swap only on a clean "greater" result; an inconsistent flag set never swaps.
  assign swap_s      = gt_s & ~eq_s & ~lt_s;
  assign load_s      = (state_r == IDLE) & start;
  assign last_i_s    = LAST_P - p_r;
  assign end_pass_s  = (i_r == last_i_s);
  assign pass_swap_s = flag_r | swap_s;
  assign finish_s    = end_pass_s & (~pass_swap_s | (p_r == LAST_P));

  // Element array, pass/pair counters, pass-swap flag and swap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ELEM; k++) elem_r[k] <= '0;
      p_r    <= '0;
      i_r    <= '0;
      flag_r <= 1'b0;
      cnt_r  <= '0;
    end else if (load_s) begin
      for (int k = 0; k < NUM_ELEM; k++) elem_r[k] <= din[k*W +: W];
      p_r    <= '0;
      i_r    <= '0;
      flag_r <= 1'b0;
      cnt_r  <= '0;
    end else if (state_r == CMP) begin
      if (swap_s) begin
        elem_r[i_r]   <= cmp_b_s;
        elem_r[i_b_s] <= cmp_a_s;
        cnt_r         <= cnt_r + CW'(1);
      end
      if (end_pass_s) begin
        if (!finish_s) begin
          p_r    <= p_r + IW'(1);
          i_r    <= '0;
          flag_r <= 1'b0;
        end
      end else begin
        i_r    <= i_r + IW'(1);
        flag_r <= pass_swap_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Next-state logic: IDLE -> CMP on start, CMP -> DONE when the sort ends.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (start)    state_nx_s = CMP;  else state_nx_s = IDLE;
      CMP:     if (finish_s) state_nx_s = DONE; else state_nx_s = CMP;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode from the next state so the registered flags track the state.
  always_comb begin
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;
    case (state_nx_s)
      CMP:     begin busy_nx_s = 1'b1; done_nx_s = 1'b0; end
      DONE:    begin busy_nx_s = 1'b1; done_nx_s = 1'b1; end
      default: begin busy_nx_s = 1'b0; done_nx_s = 1'b0; end
    endcase
  end

  // Status output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nx_s;
      done_r <= done_nx_s;
    end
  end

  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_dout
    assign dout[g*W +: W] = elem_r[g];
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign swap_count = cnt_r;

endmodule

// File: tb/tb_sort4_ctrl.sv
// Self-checking bench for sort4_ctrl: directed cases plus random vectors
// compared against a plain bubble-sort reference model.
module tb_sort4_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [15:0] dout;
  logic        busy;
  logic        done;
  logic [2:0]  swap_count;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  sort4_ctrl #(.W(4), .NUM_ELEM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .dout       (dout),
    .busy       (busy),
    .done       (done),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: early-exit bubble sort over plain signed integers.
  function automatic void model(input logic [15:0] v, output logic [15:0] s,
                                output int swaps, output int cmps);
    int a[4];
    int t;
    bit sw;
    for (int k = 0; k < 4; k++) a[k] = int'($signed(v[k*4 +: 4]));
    swaps = 0;
    cmps  = 0;
    for (int p = 0; p < 3; p++) begin
      sw = 1'b0;
      for (int i = 0; i < 3 - p; i++) begin
        cmps++;
        if (a[i] > a[i+1]) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t;
          swaps++;
          sw = 1'b1;
        end
      end
      if (!sw) break;
    end
    s = 16'h0000;
    for (int k = 0; k < 4; k++) s[k*4 +: 4] = a[k][3:0];
  endfunction

  // One full sort: start pulse, wait (bounded) for done, check result and timing.
  task automatic run_sort(input string tag, input logic [15:0] v);
    logic [15:0] exp_s;
    int exp_sw, exp_c, k;
    bit got;
    model(v, exp_s, exp_sw, exp_c);
    @(negedge clk);
    din   = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    k   = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (done) got = 1'b1;
    end
    check({tag, ".done_seen"}, 32'(got), 32'd1);
    check({tag, ".latency"}, 32'(k), 32'(exp_c));
    check({tag, ".dout"}, 32'(dout), 32'(exp_s));
    check({tag, ".swaps"}, 32'(swap_count), 32'(exp_sw));
    @(posedge clk);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".idle"}, 32'(busy), 32'd0);
    check({tag, ".dout_hold"}, 32'(dout), 32'(exp_s));
  endtask

  initial begin
    int npulse;
    logic [15:0] rv;

    // Reset state at power-up.
    #2;
    check("reset.dout", 32'(dout), 32'h0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.swaps", 32'(swap_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed sorts: mixed signs, already sorted, reversed with extremes.
    run_sort("mixed", 16'h87E3);
    check("mixed.const_dout", 32'(dout), 32'h73E8);
    check("mixed.const_swaps", 32'(swap_count), 32'd4);
    run_sort("sorted", 16'h73E8);
    check("sorted.const_swaps", 32'(swap_count), 32'd0);
    run_sort("reversed", 16'h8E37);
    check("reversed.const_dout", 32'(dout), 32'h73E8);
    check("reversed.const_swaps", 32'(swap_count), 32'd6);

    // Duplicates with a start pulse during CMP that must be ignored.
    @(negedge clk);
    din = 16'h5555; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din = 16'h1234; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    npulse = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) npulse++;
    end
    check("dup.pulses", 32'(npulse), 32'd1);
    check("dup.dout", 32'(dout), 32'h5555);
    check("dup.swaps", 32'(swap_count), 32'd0);

    // Asynchronous reset mid-sort: immediate clear, no done afterwards.
    @(negedge clk);
    din = 16'h87E3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.dout", 32'(dout), 32'h0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.swaps", 32'(swap_count), 32'd0);
    npulse = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("midrst.no_done", 32'(npulse), 32'd0);
    rst = 1'b0;
    run_sort("after_rst", 16'h87E3);

    // Randomized vectors against the reference model.
    for (int n = 0; n < 24; n++) begin
      rv = 16'($urandom);
      run_sort($sformatf("rand%0d", n), rv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
